// File: rtl/hamming_run_scheduler_if.sv
// rtl/hamming_run_scheduler_if.sv - seed source, result sink, datapath control and CSR bus of the run scheduler
interface hamming_run_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             out_ready;
    logic             out_valid;
    logic             out_startofpacket;
    logic             out_endofpacket;
    logic [WIDTH-1:0] out_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             busy;
    logic [1:0]       csr_address;
    logic             csr_read;
    logic             csr_write;
    logic [WIDTH-1:0] csr_writedata;
    logic [WIDTH-1:0] csr_readdata;
    logic             irq;

    modport master (
        input  out_ready, in_valid, in_data, busy,
               csr_address, csr_read, csr_write, csr_writedata,
        output out_valid, out_startofpacket, out_endofpacket, out_data,
               in_ready, flush, csr_readdata, irq
    );

    modport slave (
        output out_ready, in_valid, in_data, busy,
               csr_address, csr_read, csr_write, csr_writedata,
        input  out_valid, out_startofpacket, out_endofpacket, out_data,
               in_ready, flush, csr_readdata, irq
    );
endinterface

// File: rtl/hamming_run_scheduler.sv
// rtl/hamming_run_scheduler.sv - seeds one hamming datapath run, counts its results, flushes and reports the outcome
module hamming_run_scheduler #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    hamming_run_scheduler_if.master bus
);
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SEED  = 5'b00010,
        S_RUN   = 5'b00100,
        S_FLUSH = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  seed_q, cutoff_q, sh_seed_q, sh_cutoff_q;
    logic [CNTW-1:0]   limit_q, sh_limit_q, count_q, count_d;
    logic [1:0]        reason_q, reason_d;
    logic              done_q, done_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic              busy_seen_q, busy_seen_d;

    logic              wr0, start_w, abort_w, clear_w, launch;
    logic              run_beat, over_cut, hit_limit;
    logic [CNTW:0]     count_inc;
    logic [31:0]       status;

    assign wr0     = bus.csr_write && (bus.csr_address == 2'd0);
    assign start_w = wr0 && bus.csr_writedata[0];
    assign abort_w = wr0 && bus.csr_writedata[1];
    assign clear_w = wr0 && bus.csr_writedata[2];
    assign launch  = start_w && (state_q == S_IDLE);

    // Run decisions use only the shadow copies so CSR writes mid-run cannot move the goalposts.
    assign run_beat  = (state_q == S_RUN) && bus.in_valid;
    assign over_cut  = bus.in_data > sh_cutoff_q;
    assign count_inc = {1'b0, count_q} + {{CNTW{1'b0}}, 1'b1};
    assign hit_limit = (sh_limit_q != '0) && (count_inc == {1'b0, sh_limit_q});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        count_d     = count_q;
        busy_seen_d = busy_seen_q;
        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d     = S_SEED;
                    reason_d    = 2'b00;
                    count_d     = '0;
                    busy_seen_d = 1'b0;
                end
            end
            S_SEED: begin
                if (abort_w) begin
                    state_d  = S_FLUSH;
                    reason_d = 2'b11;
                end else if (bus.out_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.busy) begin
                    busy_seen_d = 1'b1;
                end
                if (abort_w) begin
                    state_d  = S_FLUSH;
                    reason_d = 2'b11;
                end else if (run_beat && over_cut) begin
                    state_d  = S_FLUSH;
                    reason_d = 2'b10;
                end else begin
                    if (run_beat && (count_q != '1)) begin
                        count_d = count_inc[CNTW-1:0];
                    end
                    if (run_beat && hit_limit) begin
                        state_d  = S_FLUSH;
                        reason_d = 2'b01;
                    end else if (busy_seen_q && !bus.busy) begin
                        state_d  = S_DONE;
                        reason_d = 2'b00;
                    end
                end
            end
            S_FLUSH: begin
                if (!bus.busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid         = 1'b0;
        bus.out_startofpacket = 1'b0;
        bus.out_endofpacket   = 1'b0;
        bus.out_data          = '0;
        bus.in_ready          = 1'b0;
        bus.flush             = 1'b0;
        case (state_q)
            S_SEED: begin
                bus.out_valid         = 1'b1;
                bus.out_startofpacket = 1'b1;
                bus.out_endofpacket   = 1'b1;
                bus.out_data          = sh_seed_q;
            end
            S_RUN: bus.in_ready = 1'b1;
            S_FLUSH: begin
                bus.in_ready = 1'b1;
                bus.flush    = 1'b1;
            end
            default: ;
        endcase
    end

    // DONE wins over a same-cycle clear so a completed run is never silently lost.
    always_comb begin
        done_d = done_q;
        if (state_q == S_DONE) begin
            done_d = 1'b1;
        end else if (launch || clear_w) begin
            done_d = 1'b0;
        end
        irq_en_d = wr0 ? bus.csr_writedata[3] : irq_en_q;
        irq_d    = done_d && irq_en_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seed_q      <= {{(WIDTH-1){1'b0}}, 1'b1};
            limit_q     <= CNTW'(16);
            cutoff_q    <= '1;
            sh_seed_q   <= '0;
            sh_limit_q  <= '0;
            sh_cutoff_q <= '0;
            count_q     <= '0;
            reason_q    <= 2'b00;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            if (bus.csr_write) begin
                case (bus.csr_address)
                    2'd1:    seed_q   <= bus.csr_writedata;
                    2'd2:    limit_q  <= bus.csr_writedata[CNTW-1:0];
                    2'd3:    cutoff_q <= bus.csr_writedata;
                    default: ;
                endcase
            end
            if (launch) begin
                sh_seed_q   <= seed_q;
                sh_limit_q  <= limit_q;
                sh_cutoff_q <= cutoff_q;
            end
            count_q     <= count_d;
            reason_q    <= reason_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        status        = '0;
        status[4:0]   = state_q;
        status[5]     = done_q;
        status[6]     = irq_en_q;
        status[9:8]   = reason_q;
        status[31:16] = 16'(count_q);
        bus.csr_readdata = '0;
        if (bus.csr_read) begin
            case (bus.csr_address)
                2'd0:    bus.csr_readdata = WIDTH'(status);
                2'd1:    bus.csr_readdata = seed_q;
                2'd2:    bus.csr_readdata = WIDTH'(limit_q);
                default: bus.csr_readdata = cutoff_q;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_run_scheduler.sv
// tb/tb_hamming_run_scheduler.sv - directed bench for hamming_run_scheduler
module tb_hamming_run_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rd;

    hamming_run_scheduler_if #(.WIDTH(32)) bus ();

    hamming_run_scheduler #(.WIDTH(32), .CNTW(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address   = a;
        bus.csr_writedata = d;
        bus.csr_write     = 1'b1;
        step();
        bus.csr_write     = 1'b0;
        bus.csr_writedata = '0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address = a;
        bus.csr_read    = 1'b1;
        #1;
        d = bus.csr_readdata;
        bus.csr_read    = 1'b0;
    endtask

    initial begin
        bus.out_ready = 0; bus.in_valid = 0; bus.in_data = '0; bus.busy = 0;
        bus.csr_address = '0; bus.csr_read = 0; bus.csr_write = 0; bus.csr_writedata = '0;
        step(); step();
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_irq", {31'b0, bus.irq}, 32'd0);
        check("reset_readdata_idle", bus.csr_readdata, 32'd0);
        reset = 1'b0;
        step();
        csr_rd(2'd0, rd); check("reset_status", rd, 32'h0000_0001);
        csr_rd(2'd1, rd); check("reset_seed", rd, 32'd1);
        csr_rd(2'd2, rd); check("reset_limit", rd, 32'd16);
        csr_rd(2'd3, rd); check("reset_cutoff", rd, 32'hFFFF_FFFF);

        // Limit run with shadowing and ignored restart
        csr_wr(2'd2, 32'd5);
        bus.out_ready = 1; bus.busy = 1;
        csr_wr(2'd0, 32'h1);
        check("lim_seed_valid", {31'b0, bus.out_valid}, 32'd1);
        check("lim_seed_data", bus.out_data, 32'd1);
        check("lim_seed_sopeop", {30'b0, bus.out_startofpacket, bus.out_endofpacket}, 32'd3);
        step();
        check("lim_in_ready", {31'b0, bus.in_ready}, 32'd1);
        csr_wr(2'd2, 32'd2);
        csr_wr(2'd0, 32'h1);
        csr_rd(2'd0, rd); check("lim_restart_ignored", rd, 32'h0000_0004);
        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = 1; bus.in_data = k;
            step();
            check("lim_flush_timing", {31'b0, bus.flush}, (k == 5) ? 32'd1 : 32'd0);
        end
        bus.in_data = 32'd6;
        step();
        bus.in_valid = 0; bus.busy = 0;
        csr_rd(2'd0, rd); check("lim_flush_count", rd, 32'h0005_0108);
        step();
        csr_rd(2'd0, rd); check("lim_done_state", rd, 32'h0005_0110);
        step();
        csr_rd(2'd0, rd); check("lim_final_status", rd, 32'h0005_0121);
        csr_rd(2'd2, rd); check("lim_limit_reg", rd, 32'd2);

        // Cutoff run
        csr_wr(2'd3, 32'd10);
        csr_wr(2'd2, 32'd0);
        bus.busy = 1;
        csr_wr(2'd0, 32'h1);
        step();
        bus.in_valid = 1;
        bus.in_data = 32'd8;  step();
        bus.in_data = 32'd9;  step();
        check("cut_no_flush_yet", {31'b0, bus.flush}, 32'd0);
        bus.in_data = 32'd12; step();
        check("cut_flush", {31'b0, bus.flush}, 32'd1);
        bus.in_valid = 0; bus.busy = 0;
        step(); step();
        csr_rd(2'd0, rd); check("cut_final_status", rd, 32'h0002_0221);

        // Seed backpressure, then abort coinciding with a cutoff beat
        csr_wr(2'd1, 32'hA5A5_0003);
        bus.out_ready = 0; bus.busy = 1;
        csr_wr(2'd0, 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid_held", {31'b0, bus.out_valid}, 32'd1);
            check("bp_data_stable", bus.out_data, 32'hA5A5_0003);
            step();
        end
        csr_rd(2'd0, rd); check("bp_still_seed", rd, 32'h0000_0002);
        bus.out_ready = 1;
        step();
        check("bp_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        csr_rd(2'd0, rd); check("bp_run", rd, 32'h0000_0004);
        bus.in_valid = 1; bus.in_data = 32'd100;
        bus.csr_address = 2'd0; bus.csr_writedata = 32'h2; bus.csr_write = 1;
        step();
        bus.csr_write = 0; bus.in_valid = 0; bus.busy = 0;
        check("abort_run_flush", {31'b0, bus.flush}, 32'd1);
        step(); step();
        csr_rd(2'd0, rd); check("abort_run_status", rd, 32'h0000_0321);

        // Abort in SEED: no seed handshake
        bus.out_ready = 0;
        csr_wr(2'd0, 32'h1);
        csr_wr(2'd0, 32'h2);
        check("abort_seed_valid", {31'b0, bus.out_valid}, 32'd0);
        check("abort_seed_flush", {31'b0, bus.flush}, 32'd1);
        step(); step();
        csr_rd(2'd0, rd); check("abort_seed_status", rd, 32'h0000_0321);

        // Natural finish with interrupt
        bus.out_ready = 1; bus.busy = 1;
        csr_wr(2'd0, 32'h9);
        step();
        bus.in_valid = 1; bus.in_data = 32'd7;
        step();
        bus.in_valid = 0; bus.busy = 0;
        step();
        check("nat_no_flush", {31'b0, bus.flush}, 32'd0);
        csr_rd(2'd0, rd); check("nat_done_state", rd, 32'h0001_0050);
        step();
        check("nat_irq", {31'b0, bus.irq}, 32'd1);
        csr_rd(2'd0, rd); check("nat_status", rd, 32'h0001_0061);
        csr_wr(2'd0, 32'hC);
        check("clr_irq", {31'b0, bus.irq}, 32'd0);
        csr_rd(2'd0, rd); check("clr_status", rd, 32'h0001_0041);

        // Reset in RUN
        csr_wr(2'd1, 32'h55);
        bus.busy = 1;
        csr_wr(2'd0, 32'h9);
        step();
        bus.in_valid = 1; bus.in_data = 32'd3;
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_flush", {31'b0, bus.flush}, 32'd0);
        check("rst_irq", {31'b0, bus.irq}, 32'd0);
        csr_rd(2'd0, rd); check("rst_status", rd, 32'h0000_0001);
        bus.in_valid = 0; bus.busy = 0;
        step();
        reset = 1'b0;
        step();
        csr_rd(2'd1, rd); check("rst_seed", rd, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
